// File: rtl/multi_reg_calculator.sv
// Push-button calculator: NREG registers, add/subtract, NDIG-digit seven-segment display.
// Binary-to-BCD uses an iterative shift-add-3 converter; busy is high while it runs.
module multi_reg_calculator #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int NDIG  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5+NREG:0]   pb,
    output logic [7*NDIG-1:0] ss,
    output logic              red,
    output logic              blue,
    output logic              busy
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [7*NDIG-1:0] SS_ZERO = {NDIG{7'b0111111}};

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;

    generate
        if (pow10(NDIG) <= MAXV) begin : g_ndig_chk
            $error("NDIG too small to display 2^WIDTH-1");
        end
        if (NREG < 2 || NREG > 8) begin : g_nreg_chk
            $error("NREG must be in 2..8");
        end
    endgenerate

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1100111;
            default: return 7'b0000000;
        endcase
    endfunction

    typedef enum logic [2:0] {IDLE, WRITE, RSEL_A, RSEL_B, ROP, SHOW} state_t;

    state_t              state_q, state_d;
    logic [5+NREG:0]     pb_q, pb_d, press;
    logic [WIDTH-1:0]    entry_q, entry_d;
    logic [WIDTH-1:0]    regs_q [NREG];
    logic [WIDTH-1:0]    regs_d [NREG];
    logic [IW-1:0]       a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                red_q, red_d, blue_q, blue_d;
    logic [WIDTH-1:0]    disp_val, disp_last_q, disp_last_d;
    logic [WIDTH-1:0]    bin_q, bin_d, bin_sh;
    logic [BW-1:0]       bcd_q, bcd_d, bcd_adj, bcd_sh;
    logic [BW+WIDTH-1:0] shift_full;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [7*NDIG-1:0]   ss_q, ss_d;

    logic          p_write, p_read, p_bit, bit_val, p_add, p_sub, p_reg;
    logic [IW-1:0] reg_sel;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pb_q        <= '0;
            entry_q     <= '0;
            regs_q      <= '{default: '0};
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            red_q       <= 1'b0;
            blue_q      <= 1'b0;
            disp_last_q <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            ss_q        <= SS_ZERO;
        end else begin
            state_q     <= state_d;
            pb_q        <= pb_d;
            entry_q     <= entry_d;
            regs_q      <= regs_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            red_q       <= red_d;
            blue_q      <= blue_d;
            disp_last_q <= disp_last_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            ss_q        <= ss_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        pb_d    = pb;
        press   = pb & ~pb_q;
        p_write = 1'b0;
        p_read  = 1'b0;
        p_bit   = 1'b0;
        bit_val = 1'b0;
        p_add   = 1'b0;
        p_sub   = 1'b0;
        p_reg   = 1'b0;
        reg_sel = '0;
        if (press[2]) begin
            p_write = 1'b1;
        end else if (press[3]) begin
            p_read = 1'b1;
        end else begin
            if (press[0]) begin
                p_bit = 1'b1;
            end else if (press[1]) begin
                p_bit   = 1'b1;
                bit_val = 1'b1;
            end
            if (press[4]) p_add = 1'b1;
            else if (press[5]) p_sub = 1'b1;
            // Scan downwards so the lowest pressed index is the one kept
            for (int i = NREG - 1; i >= 0; i--) begin
                if (press[6+i]) begin
                    p_reg   = 1'b1;
                    reg_sel = IW'(i);
                end
            end
        end

        state_d  = state_q;
        entry_d  = entry_q;
        regs_d   = regs_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        red_d    = red_q;
        blue_d   = blue_q;

        if (p_write) begin
            state_d = WRITE;
            entry_d = '0;
        end else begin
            case (state_q)
                IDLE: if (p_read) state_d = RSEL_A;
                WRITE: begin
                    if (p_read) begin
                        state_d = RSEL_A;
                    end else if (p_bit) begin
                        entry_d = {entry_q[WIDTH-2:0], bit_val};
                    end else if (p_reg) begin
                        regs_d[reg_sel] = entry_q;
                        entry_d         = '0;
                    end
                end
                RSEL_A: if (p_reg) begin
                    a_d     = reg_sel;
                    state_d = RSEL_B;
                end
                RSEL_B: if (p_reg) begin
                    b_d     = reg_sel;
                    state_d = ROP;
                end
                ROP: begin
                    if (p_add) begin
                        {red_d, result_d} = {1'b0, regs_q[a_q]} + {1'b0, regs_q[b_q]};
                        blue_d  = 1'b0;
                        state_d = SHOW;
                    end else if (p_sub) begin
                        if (regs_q[a_q] >= regs_q[b_q]) begin
                            result_d = regs_q[a_q] - regs_q[b_q];
                            blue_d   = 1'b0;
                        end else begin
                            result_d = regs_q[b_q] - regs_q[a_q];
                            blue_d   = 1'b1;
                        end
                        red_d   = 1'b0;
                        state_d = SHOW;
                    end
                end
                SHOW: if (p_read) state_d = RSEL_A;
                default: state_d = IDLE;
            endcase
        end
        if (state_d != SHOW) begin
            red_d  = 1'b0;
            blue_d = 1'b0;
        end

        // BCD converter: a change of displayed value restarts it, aborting any run in flight
        bcd_adj = bcd_q;
        for (int d = 0; d < NDIG; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        shift_full = {bcd_adj, bin_q} << 1;
        bcd_sh     = shift_full[BW+WIDTH-1:WIDTH];
        bin_sh     = shift_full[WIDTH-1:0];

        disp_last_d = disp_val;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        ss_d        = ss_q;
        if (disp_val != disp_last_q) begin
            bin_d  = disp_val;
            bcd_d  = '0;
            cnt_d  = CW'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            bin_d = bin_sh;
            bcd_d = bcd_sh;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                for (int d = 0; d < NDIG; d++) ss_d[7*d +: 7] = seg7(bcd_sh[4*d +: 4]);
            end
        end
    end

    // Outputs
    always_comb begin
        case (state_q)
            WRITE:   disp_val = entry_q;
            SHOW:    disp_val = result_q;
            default: disp_val = '0;
        endcase
        ss   = ss_q;
        red  = red_q;
        blue = blue_q;
        busy = busy_q;
    end
endmodule
